ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Upstream stage of the sprite movement logic.
- Receives raw PS/2 keyboard clock/data lines, deframes 11-bit scan-set-2 frames, and tracks make/break/extended prefixes.
- Presents a held 8-bit key_code: the scancode of the currently pressed key, or 0x00 when released.
- key_code connects directly to the sprite controller's key_code input (e.g. arrows 0x75/0x72/0x6B/0x74).

Parameters:
- FILTER_LEN, 8: consecutive clk cycles the synchronized ps2_clk must be stable before the filtered clock changes.
- TIMEOUT_CYCLES, 50000: max clk cycles between ps2_clk falling edges inside a frame (1 ms at 50 MHz); used only with PS2_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  input  1  raw PS/2 data from keyboard, asynchronous
- key_code  output  8  scancode of held key; 0x00 = none
- extended  output  1  1 if the held key was E0-prefixed
- key_valid  output  1  one-cycle pulse on each accepted make code, including typematic repeats
- frame_err  output  1  one-cycle pulse on each rejected or aborted frame

Behaviour:
- Reset (async, active-high):
  - key_code=0x00, extended=0, key_valid=0, frame_err=0.
  - Frame FSM to IDLE; E0/F0 flags cleared; bit counter 0; filtered clock=1.
  - Asserting reset mid-frame discards the partial frame.
- Sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- Filter:
  - Filtered clock takes the synced ps2_clk value only after FILTER_LEN equal consecutive samples; shorter glitches are ignored.
  - Data is sampled on a filtered-clock falling edge (1→0 detect, one clk after the filter updates).
- Frame FSM, advancing only on falling-edge cycles:
  - IDLE: data=0 → DATA, counter=0. data=1 → stay IDLE, no error.
  - DATA: shift data in LSB-first; after 8th bit → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: frame good iff stop bit=1 and the 8 data bits plus parity bit contain an odd number of 1s. Good → byte_rdy (internal) for 1 cycle. Bad → frame_err pulse, byte discarded, prefix flags untouched. Either way → IDLE.
- Prefix decode, on byte_rdy:
  - 0xE0: set ext flag.
  - 0xF0: set brk flag.
  - Any other byte b, with brk=1: if b==key_code, key_code<=0x00 and extended<=0; otherwise no output change. Clear both flags.
  - Any other byte b, with brk=0: key_code<=b, extended<=ext, key_valid=1 for one cycle. Clear both flags.
- Latency: key_code/extended/key_valid update on the clk edge after byte_rdy, i.e. 2 clk cycles after the stop-bit falling edge is detected.
- Held value: key_code stays stable between frames; no output changes except on byte_rdy or reset.
- Only one key is tracked. A new make overwrites the previous key; a break for a non-held key is ignored.
- The block never drives ps2_clk/ps2_data (receive-only).

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined: a counter runs while FSM≠IDLE and clears on each falling edge. When it reaches TIMEOUT_CYCLES: FSM→IDLE, partial frame discarded, frame_err pulses one cycle, prefix flags cleared. This resynchronises after a lost edge.
- Undefined: no counter; the FSM waits indefinitely for the next edge and TIMEOUT_CYCLES is unused.

Test Plan:
(Bench: FILTER_LEN=4, TIMEOUT_CYCLES=2000, ps2_clk half-period 20 clk.)
1. Frames E0, 75 → key_valid exactly one pulse; key_code=0x75, extended=1 two cycles after the 2nd stop edge.
2. After test 1, send E0, F0, 75 → key_code=0x00, extended=0, no key_valid pulse.
3. Send 6B, then F0, 74 → key_code stays 0x6B. Then send F0, 6B → key_code=0x00.
4. Send byte 0x72 with wrong (even) parity, and separately a frame with stop=0 → frame_err pulses once per frame, key_code unchanged. A following good 72 frame → key_code=0x72.
5. Inject 2-cycle low glitches on ps2_clk during IDLE and mid-frame, then send 0x74 → no extra bits shifted, key_code=0x74, no frame_err.
6. Timeout and reset:
   - With PS2_TIMEOUT_EN: stop after 5 data edges → frame_err pulses 2000 cycles after the last edge; a next full 0x75 frame decodes correctly.
   - Assert reset mid-frame → all outputs 0 immediately; the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 receive-only keyboard decoder: sync, clock filter, 11-bit frame deframer, make/break/E0 tracking.
// Optional frame timeout is enabled by defining PS2_TIMEOUT_EN.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);

  state_t        r_state, w_state_nxt;
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt_clk, r_filt_prev;
  logic [FW-1:0] r_filt_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par, r_byte_rdy, r_ext, r_brk;
  logic          w_fall, w_good, w_bad, w_timeout;

  // Filtered clock only follows the synced line after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_filt_prev & ~r_filt_clk;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
`else
  // No timeout in this build; the frame FSM waits indefinitely for the next edge.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_bad       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          // Good frame: stop bit high and odd parity over data plus parity bit.
          if (r_dat_s2 && (^{r_shift, r_par})) w_good = 1'b1;
          else                                 w_bad  = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_byte_rdy <= 1'b0;
    end else begin
      r_byte_rdy <= w_good;
      if (w_fall && !w_timeout) begin
        if (r_state == S_IDLE) r_bit_cnt <= '0;
        if (r_state == S_DATA) begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (r_state == S_PARITY) r_par <= r_dat_s2;
      end
    end
  end

  // key_valid and frame_err are single-cycle strobes with no back-pressure; consumers must sample every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= 8'h00;
      extended  <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= w_bad;
      if (w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_rdy) begin
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (r_brk) begin
            if (r_shift == key_code) begin
              key_code <= 8'h00;
              extended <= 1'b0;
            end
          end else begin
            key_code  <= r_shift;
            extended  <= r_ext;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
